// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Contains:
//   - the default operand width
//   - TRUE/FALSE constants
//   - the funct3 op encodings
//   - the controller state type
//   - small op-decode helpers used by the controller
package muldiv_pkg;

  localparam int unsigned XlenDefault = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StBusy,
    StFix,
    StDone
  } muldiv_state_e;

  function automatic logic op_is_div(muldiv_op_e op);
    return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
  endfunction

  function automatic logic op_is_rem(muldiv_op_e op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

  function automatic logic op_src1_signed(muldiv_op_e op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic op_src2_signed(muldiv_op_e op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iterative multiply/divide datapath. One step per step_i cycle.
// Ports:
//   clk_i, rst_ni - clock, async active-low reset
//   load_i        - load op_a_i into the accumulator low half, op_b_i into the operand reg
//   step_i        - perform one iteration
//   div_mode_i    - sampled on load: 1 = restoring divide, 0 = shift-add multiply
//   op_a_i/op_b_i - multiplier/multiplicand or dividend/divisor (unsigned)
//   acc_o         - accumulator; after XLEN steps: product, or {remainder, quotient}
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_mode_i,
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              div_q, div_d;

  logic [XLEN-1:0]   hi, lo;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign hi = acc_q[2*XLEN-1:XLEN];
  assign lo = acc_q[XLEN-1:0];

  // Multiply: add multiplicand to the high half when the multiplier LSB is set, then shift
  // right with the carry moving into the top bit.
  assign add_sum  = {1'b0, hi} + {1'b0, (lo[0] ? b_q : {XLEN{1'b0}})};
  assign mul_next = {add_sum, lo[XLEN-1:1]};

  // Divide: shift the next dividend bit into the partial remainder; subtract when it fits.
  assign rem_shift = acc_q[2*XLEN-1:XLEN-1];
  assign rem_diff  = rem_shift - {1'b0, b_q};
  assign rem_ge    = (rem_shift >= {1'b0, b_q});
  assign div_next  = {(rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0]),
                      lo[XLEN-2:0], rem_ge};

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    div_d = div_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, op_a_i};
      b_d   = op_b_i;
      div_d = div_mode_i;
    end else if (step_i) begin
      acc_d = div_q ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide controller. Owns the FSM, iteration counter, special-case detection,
// operand sign preparation and result sign fix-up; iteration runs in muldiv_core.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   ex_muldiv_req       - EX holds an M instruction (held stable while stalled)
//   ex_muldiv_op        - funct3
//   ex_src1, ex_src2    - operands
//   pipe_flush          - abandon any operation, return to IDLE
//   muldiv_stall        - stall request to pipe_ctrl
//   muldiv_done         - muldiv_result valid this cycle
//   muldiv_result       - rd write data (held outside DONE)
//   muldiv_busy         - FSM not in IDLE
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XlenDefault,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_muldiv_req,
  input  logic [2:0]      ex_muldiv_op,
  input  logic [XLEN-1:0] ex_src1,
  input  logic [XLEN-1:0] ex_src2,
  input  logic            pipe_flush,
  output logic            muldiv_stall,
  output logic            muldiv_done,
  output logic [XLEN-1:0] muldiv_result,
  output logic            muldiv_busy
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN - 1);

  muldiv_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  muldiv_op_e        op_q, op_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_e        op_in;
  logic              src1_neg, src2_neg;
  logic [XLEN-1:0]   abs1, abs2;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_result;
  logic [XLEN-1:0]   fix_result;

  logic              core_load, core_step;
  logic [2*XLEN-1:0] core_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Operand decode (valid while the request is held in IDLE/PREP)
  assign op_in    = muldiv_op_e'(ex_muldiv_op);
  assign src1_neg = op_src1_signed(op_in) & ex_src1[XLEN-1];
  assign src2_neg = op_src2_signed(op_in) & ex_src2[XLEN-1];
  assign abs1     = src1_neg ? -ex_src1 : ex_src1;
  assign abs2     = src2_neg ? -ex_src2 : ex_src2;

  // Cases resolved without iterating: divide by zero and signed MIN / -1
  assign div_zero = op_is_div(op_in) && (ex_src2 == '0);
  assign div_ovf  = ((op_in == OpDiv) || (op_in == OpRem)) &&
                    (ex_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (ex_src2 == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_result = '0;
    if (div_zero) begin
      special_result = op_is_rem(op_in) ? ex_src1 : '1;
    end else if (div_ovf) begin
      special_result = op_is_rem(op_in) ? '0 : ex_src1;
    end
  end

  // Sign fix-up of the unsigned core result
  assign prod_fix = neg_res_q ? -core_acc : core_acc;
  assign quo_fix  = neg_res_q ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0];
  assign rem_fix  = neg_rem_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    unique case (op_q)
      OpMul:                     fix_result = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_result = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_result = quo_fix;
      OpRem, OpRemu:             fix_result = rem_fix;
      default:                   fix_result = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything including a new request
  always_comb begin
    state_d = state_q;
    if (pipe_flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ex_muldiv_req) begin
            state_d = special ? StDone : StPrep;
          end
        end
        StPrep:  state_d = StBusy;
        StBusy:  state_d = (cnt_q == CntLast) ? StFix : StBusy;
        StFix:   state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    muldiv_done   = (state_q == StDone);
    muldiv_busy   = (state_q != StIdle);
    muldiv_stall  = ex_muldiv_req & ~muldiv_done;
    muldiv_result = result_q;
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    core_load = False;
    core_step = False;
    if (!pipe_flush) begin
      unique case (state_q)
        StIdle: begin
          if (ex_muldiv_req && special) begin
            result_d = special_result;
          end
        end
        StPrep: begin
          cnt_d     = '0;
          op_d      = op_in;
          neg_res_d = src1_neg ^ src2_neg;
          neg_rem_d = src1_neg;
          core_load = True;
        end
        StBusy: begin
          cnt_d     = cnt_q + 1'b1;
          core_step = True;
        end
        StFix: begin
          result_d = fix_result;
        end
        StDone: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= OpMul;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  muldiv_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (core_load),
    .step_i     (core_step),
    .div_mode_i (op_is_div(op_in)),
    .op_a_i     (abs1),
    .op_b_i     (abs2),
    .acc_o      (core_acc)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, results, special cases, flush and reset.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req = 1'b0;
  logic [2:0]      op = 3'b000;
  logic [XLEN-1:0] src1 = '0;
  logic [XLEN-1:0] src2 = '0;
  logic            flush = 1'b0;
  logic            stall, done, busy;
  logic [XLEN-1:0] res;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(
    .XLEN  (XLEN),
    .CNT_W (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_muldiv_req (req),
    .ex_muldiv_op  (op),
    .ex_src1       (src1),
    .ex_src2       (src2),
    .pipe_flush    (flush),
    .muldiv_stall  (stall),
    .muldiv_done   (done),
    .muldiv_result (res),
    .muldiv_busy   (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Call just after a rising edge with the FSM in IDLE; that cycle is cycle 0.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc,
                        input bit scramble);
    int cyc;
    int bad;
    bit seen;
    op   = o;
    src1 = a;
    src2 = b;
    req  = 1'b1;
    cyc  = 0;
    bad  = 0;
    seen = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (stall !== 1'b1 || busy !== (cyc != 0)) bad++;
      @(posedge clk);
      #1;
      cyc++;
      if (scramble && cyc >= 2) begin
        src1 = $urandom;
        src2 = $urandom;
      end
    end
    check_val({tag, " done_seen"}, 32'(seen), 32'd1);
    check_val({tag, " done_cycle"}, cyc, exp_cyc);
    check_val({tag, " result"}, res, exp_res);
    check_val({tag, " stall_while_waiting"}, bad, 0);
    check_val({tag, " stall_at_done"}, 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    check_val({tag, " after_done"}, {30'd0, done, busy}, 32'd0);
    check_val({tag, " result_hold"}, res, exp_res);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check_val("reset done", 32'(done), 32'd0);
    check_val("reset busy", 32'(busy), 32'd0);
    check_val("reset result", res, 32'd0);
    check_val("reset stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Operands scrambled during BUSY must not affect the result
    run_op("mul_7x-3", OpMul, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 35, 1'b1);
    run_op("mulhu_ff", OpMulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 1'b0);
    run_op("mulh_ff", OpMulh, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35, 1'b0);
    run_op("mulhsu_ff", OpMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 1'b0);
    run_op("div_-7/2", OpDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35, 1'b1);
    run_op("rem_-7/2", OpRem, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35, 1'b0);
    run_op("divu_big", OpDivu, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 35, 1'b0);
    run_op("remu_big", OpRemu, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35, 1'b0);

    // Special cases complete in one cycle
    run_op("div_5/0", OpDiv, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    run_op("divu_5/0", OpDivu, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    run_op("remu_5/0", OpRemu, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op("div_ovf", OpDiv, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run_op("rem_ovf", OpRem, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0);

    // Flush wins over a same-cycle request in IDLE
    op    = OpDiv;
    src1  = 32'd9;
    src2  = 32'd0;
    req   = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    req   = 1'b0;
    #1;
    check_val("flush_vs_req busy", 32'(busy), 32'd0);
    check_val("flush_vs_req result", res, 32'd0);
    @(posedge clk);
    #1;

    // Flush in BUSY (counter 10): back to IDLE, no done pulse, then a fresh DIVU
    op   = OpMul;
    src1 = 32'd1234;
    src2 = 32'd5678;
    req  = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_val("pre_flush busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    req   = 1'b0;
    #1;
    check_val("post_flush state", {30'd0, done, busy}, 32'd0);
    run_op("divu_100/7", OpDivu, 32'd100, 32'd7, 32'd14, 35, 1'b0);

    // Reset mid-operation, then back-to-back ops
    op   = OpMul;
    src1 = 32'd99;
    src2 = 32'd77;
    req  = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    check_val("midreset busy", 32'(busy), 32'd0);
    check_val("midreset done", 32'(done), 32'd0);
    check_val("midreset result", res, 32'd0);
    check_val("midreset stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("mul_3x4", OpMul, 32'd3, 32'd4, 32'd12, 35, 1'b0);
    run_op("div_12/4", OpDiv, 32'd12, 32'd4, 32'd3, 35, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
